// File: rtl/pipeline_stage_buf.sv
// Purpose: one-deep pipeline register with a skid slot and a saturating downstream-stall counter.
// Latency: 1 cycle from accept to out_valid when empty; sustains one beat per cycle with out_ready held high.
// Backpressure: in_ready is registered-state only (not FULL and no flush); one skid beat absorbs a downstream stall.
module pipeline_stage_buf #(
   parameter int                 WIDTH  = 32,
   parameter logic [WIDTH-1:0]   BUBBLE = '0,
   parameter int                 CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] HALF  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_nxt;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_nxt;
   logic             accept;
   logic             drain;

   // in_ready depends only on held state and flush, so out_ready never reaches it combinationally.
   assign in_ready  = (state != FULL) && !flush;
   assign out_valid = (state != EMPTY);
   assign out_data  = out_valid ? main_q : BUBBLE;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // Occupancy transitions; flush overrides everything and squashes both slots.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = HALF;
               main_nxt  = in_data;
            end
         end
         HALF: begin
            case ({accept, drain})
               2'b11: main_nxt = in_data;
               2'b10: begin
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end
               2'b01: begin
                  state_nxt = EMPTY;
                  main_nxt  = BUBBLE;
               end
               default: ;
            endcase
         end
         FULL: begin
            // No accept is possible here: in_ready is low while FULL.
            if (drain) begin
               state_nxt = HALF;
               main_nxt  = skid_q;
               skid_nxt  = BUBBLE;
            end
         end
         default: begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
         end
      endcase
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = BUBBLE;
         skid_nxt  = BUBBLE;
      end
   end

   // Occupancy and payload registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= EMPTY;
         main_q <= BUBBLE;
         skid_q <= BUBBLE;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

   // Count cycles where a valid beat is held back by downstream; saturates, ignores flush.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: doc/pipeline_stage_buf.md
PIPELINE_STAGE_BUF -- requirements
Module: pipeline_stage_buf

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload width in bits.
REQ-002 Parameter BUBBLE, default all-zeros (WIDTH bits), SHALL set the payload value driven when no valid data is held.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-004 Port CLK, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port flush, input, 1 bit: synchronous squash of all held beats.
REQ-007 Port in_valid, input, 1 bit: upstream beat present.
REQ-008 Port in_data, input, WIDTH bits: upstream payload.
REQ-009 Port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-010 Port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-011 Port out_data, output, WIDTH bits: downstream payload.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the beat this cycle.
REQ-013 Port stall_cnt, output, CNT_W bits: saturating count of downstream stall cycles.

Function
REQ-014 Occupancy SHALL be tracked as a 3-state FSM: EMPTY (0 beats), HALF (1 beat, in main register), FULL (2 beats, main plus skid register).
REQ-015 Accept SHALL be defined as in_valid & in_ready; drain SHALL be defined as out_valid & out_ready.
REQ-016 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data SHALL equal the main register and SHALL be BUBBLE whenever out_valid = 0.
REQ-017 in_ready SHALL equal (state != FULL) & ~flush, with no combinational path from out_ready to in_ready.
REQ-018 From EMPTY, accept SHALL go to HALF with main <= in_data.
REQ-019 From HALF, accept with drain SHALL stay in HALF with main <= in_data.
REQ-020 From HALF, accept without drain SHALL go to FULL with skid <= in_data.
REQ-021 From HALF, drain without accept SHALL go to EMPTY with main <= BUBBLE.
REQ-022 From FULL, drain SHALL go to HALF with main <= skid and skid <= BUBBLE; FULL without drain SHALL hold both registers.
REQ-023 Latency SHALL be 1 cycle: a beat accepted in cycle N SHALL appear with out_valid = 1 in cycle N+1 when the block was EMPTY.
REQ-024 With out_ready held at 1, throughput SHALL be one beat per cycle sustained.
REQ-025 Beats SHALL leave in acceptance order, with no loss or duplication outside flush.
REQ-026 flush SHALL have priority over every transfer: next state EMPTY, and main and skid SHALL both be written to BUBBLE.
REQ-027 A drain occurring in the flush cycle SHALL count as completed.
REQ-028 in_ready SHALL be 0 during the flush cycle, so no beat is accepted in that cycle.
REQ-029 stall_cnt SHALL increment by 1 in each cycle where out_valid = 1 and out_ready = 0.
REQ-030 stall_cnt SHALL saturate at 2^CNT_W-1.
REQ-031 stall_cnt SHALL be unaffected by flush.

Reset
REQ-032 nRST = 0 SHALL immediately force, independent of CLK: state EMPTY, main = skid = BUBBLE, stall_cnt = 0, out_valid = 0, in_ready = 1.
REQ-033 Reset asserted mid-operation SHALL discard all held beats; after release, the first accepted beat SHALL behave as from EMPTY.
REQ-034 Outputs SHALL be stable with no spurious transfer in the first rising edge after nRST deasserts.

Verification
REQ-035 Streaming: after reset, in_valid = 1 with data 1,2,3,4 on consecutive cycles and out_ready = 1 -> out_data 1,2,3,4 on cycles 1-4, in_ready stays 1.
REQ-036 Backpressure: out_ready = 0 while sending 0xA, 0xB -> state FULL, in_ready = 0, stall_cnt increments each cycle; then out_ready = 1 -> 0xA then 0xB drained, in_ready = 1 one cycle after the first drain.
REQ-037 Flush while FULL, with in_valid = 1 and data 0xC -> next cycle out_valid = 0, out_data = BUBBLE, 0xC never appears, stall_cnt unchanged.
REQ-038 Saturation: CNT_W = 4, out_valid = 1, out_ready = 0 for 20 cycles -> stall_cnt = 15 and holds at 15.
REQ-039 Async reset pulse between clock edges while HALF -> out_valid = 0 and stall_cnt = 0 before the next CLK edge.
REQ-040 Random valid/ready stimulus for 10k cycles -> scoreboard shows in-order delivery, zero loss, zero duplication.
